// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// Perf counter signals exist only when MC_PERF_CNT_EN is defined.
interface mc_ctrl_if;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        irwrite;
    logic        pcwrite;
    logic [1:0]  brctr;
    logic [1:0]  wactr;
    logic [1:0]  wdctr;
    logic        extctr;
    logic        bctr;
    logic [2:0]  aluctr;
    logic        regwrite;
    logic        memwrite;
    logic [2:0]  state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;
`endif

    modport master (
        input  op, func,
        output irwrite, pcwrite, brctr, wactr, wdctr,
        output extctr, bctr, aluctr, regwrite, memwrite,
        output state
`ifdef MC_PERF_CNT_EN
        , output cyc_cnt, ret_cnt
`endif
    );

    modport slave (
        output op, func,
        input  irwrite, pcwrite, brctr, wactr, wdctr,
        input  extctr, bctr, aluctr, regwrite, memwrite,
        input  state
`ifdef MC_PERF_CNT_EN
        , input cyc_cnt, ret_cnt
`endif
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXE/MEM/WB sequencer.
// Optional MC_PERF_CNT_EN adds cycle and retired-instruction counters.
module mc_ctrl #(
    parameter int IMEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.master   bus
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DEC   = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0] C_NOP   = 4'd0;
    localparam logic [3:0] C_ADDU  = 4'd1;
    localparam logic [3:0] C_SUBU  = 4'd2;
    localparam logic [3:0] C_JR    = 4'd3;
    localparam logic [3:0] C_ORI   = 4'd4;
    localparam logic [3:0] C_LUI   = 4'd5;
    localparam logic [3:0] C_LW    = 4'd6;
    localparam logic [3:0] C_SW    = 4'd7;
    localparam logic [3:0] C_BEQ   = 4'd8;
    localparam logic [3:0] C_J     = 4'd9;
    localparam logic [3:0] C_JAL   = 4'd10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    localparam logic [1:0] BR_SEQ  = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_JMP  = 2'b10;
    localparam logic [1:0] BR_JR   = 2'b11;

    localparam logic [1:0] WA_RT   = 2'b00;
    localparam logic [1:0] WA_RD   = 2'b01;
    localparam logic [1:0] WA_31   = 2'b10;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_DM   = 2'b01;
    localparam logic [1:0] WD_PC4  = 2'b10;

    localparam logic [3:0] WAIT_C  = 4'(IMEM_WAIT);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cls;

    logic       ex_ext;
    logic       ex_b;
    logic [2:0] ex_alu;

    logic       irw, pcw, rgw, mmw;
    logic [1:0] br, wa, wd;
    logic       ext, bsel;
    logic [2:0] alu;

    always_comb begin
        cls = C_NOP;
        case (bus.op)
            OP_R: begin
                case (bus.func)
                    FN_ADDU: cls = C_ADDU;
                    FN_SUBU: cls = C_SUBU;
                    FN_JR:   cls = C_JR;
                    default: cls = C_NOP;
                endcase
            end
            OP_ORI:  cls = C_ORI;
            OP_LUI:  cls = C_LUI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_NOP;
        endcase
    end

    // ALU-side selectors set in EXE and held through MEM/WB so the
    // datapath result stays stable up to the write edge.
    always_comb begin
        ex_ext = 1'b0;
        ex_b   = 1'b0;
        ex_alu = ALU_ADD;
        case (cls)
            C_SUBU, C_BEQ: ex_alu = ALU_SUB;
            C_ORI: begin
                ex_b   = 1'b1;
                ex_alu = ALU_OR;
            end
            C_LUI: begin
                ex_b   = 1'b1;
                ex_alu = ALU_LUI;
            end
            C_LW, C_SW: begin
                ex_ext = 1'b1;
                ex_b   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        cnt_d   = cnt_q;
        irw     = 1'b0;
        pcw     = 1'b0;
        rgw     = 1'b0;
        mmw     = 1'b0;
        br      = BR_SEQ;
        wa      = WA_RT;
        wd      = WD_ALU;
        ext     = 1'b0;
        bsel    = 1'b0;
        alu     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                if (cnt_q == WAIT_C) begin
                    irw     = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_DEC;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = S_FETCH;
                end
            end
            S_DEC: begin
                case (cls)
                    C_JR: begin
                        pcw = 1'b1;
                        br  = BR_JR;
                    end
                    C_J: begin
                        pcw = 1'b1;
                        br  = BR_JMP;
                    end
                    // Link write and PC update share one edge.
                    C_JAL: begin
                        pcw = 1'b1;
                        br  = BR_JMP;
                        rgw = 1'b1;
                        wa  = WA_31;
                        wd  = WD_PC4;
                    end
                    C_ADDU, C_SUBU, C_ORI, C_LUI,
                    C_LW, C_SW, C_BEQ: state_d = S_EXE;
                    default: pcw = 1'b1;
                endcase
            end
            S_EXE: begin
                ext  = ex_ext;
                bsel = ex_b;
                alu  = ex_alu;
                case (cls)
                    C_ADDU, C_SUBU,
                    C_ORI, C_LUI: state_d = S_WB;
                    C_LW, C_SW:   state_d = S_MEM;
                    C_BEQ: begin
                        pcw = 1'b1;
                        br  = BR_BEQ;
                    end
                    default: pcw = 1'b1;
                endcase
            end
            S_MEM: begin
                ext  = ex_ext;
                bsel = ex_b;
                alu  = ex_alu;
                case (cls)
                    C_LW: state_d = S_WB;
                    C_SW: begin
                        mmw = 1'b1;
                        pcw = 1'b1;
                    end
                    default: pcw = 1'b1;
                endcase
            end
            S_WB: begin
                ext  = ex_ext;
                bsel = ex_b;
                alu  = ex_alu;
                pcw  = 1'b1;
                case (cls)
                    C_ADDU, C_SUBU: begin
                        rgw = 1'b1;
                        wa  = WA_RD;
                    end
                    C_ORI, C_LUI: rgw = 1'b1;
                    C_LW: begin
                        rgw = 1'b1;
                        wd  = WD_DM;
                    end
                    default: ;
                endcase
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Enables are gated by rst so nothing writes while reset is held.
    assign bus.irwrite  = irw & rst;
    assign bus.pcwrite  = pcw & rst;
    assign bus.regwrite = rgw & rst;
    assign bus.memwrite = mmw & rst;
    assign bus.brctr    = br;
    assign bus.wactr    = wa;
    assign bus.wdctr    = wd;
    assign bus.extctr   = ext;
    assign bus.bctr     = bsel;
    assign bus.aluctr   = alu;
    assign bus.state    = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] ret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= 32'd0;
            ret_q <= 32'd0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (pcw)
                ret_q <= ret_q + 32'd1;
        end
    end

    assign bus.cyc_cnt = cyc_q;
    assign bus.ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: spec table, random model, corner cases.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst2 = 1'b0;

    always #5 clk = ~clk;

    mc_ctrl_if mif ();
    mc_ctrl_if mif2 ();

    mc_ctrl #(.IMEM_WAIT(0)) u0 (.clk(clk), .rst(rst), .bus(mif));
    mc_ctrl #(.IMEM_WAIT(2)) u2 (.clk(clk), .rst(rst2), .bus(mif2));

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       ir;
        logic       pc;
        logic [1:0] br;
        logic [1:0] wa;
        logic [1:0] wd;
        logic       ext;
        logic       b;
        logic [2:0] alu;
        logic       rw;
        logic       mw;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        int         ncyc;
        logic [1:0] br;
        logic       rw;
        logic       mw;
    } vec_t;

    obs_t exp_q[$];

    function automatic obs_t get_obs();
        obs_t o;
        o.st  = mif.state;
        o.ir  = mif.irwrite;
        o.pc  = mif.pcwrite;
        o.br  = mif.brctr;
        o.wa  = mif.wactr;
        o.wd  = mif.wdctr;
        o.ext = mif.extctr;
        o.b   = mif.bctr;
        o.alu = mif.aluctr;
        o.rw  = mif.regwrite;
        o.mw  = mif.memwrite;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Reference: per-instruction list of cycles; selectors are sticky,
    // only the fields the instruction names in a state are changed.
    task automatic build(input logic [5:0] op, input logic [5:0] fn);
        obs_t c;
        exp_q.delete();
        c = '0;
        c.ir = 1'b1;
        exp_q.push_back(c);
        c.ir = 1'b0;
        c.st = 3'd1;
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
            exp_q.push_back(c);
            c.st = 3'd2; c.b = 1'b0; c.alu = (fn == 6'h23) ? 3'd1 : 3'd0;
            exp_q.push_back(c);
            c.st = 3'd4; c.wa = 2'd1; c.wd = 2'd0; c.br = 2'd0;
            c.rw = 1'b1; c.pc = 1'b1;
            exp_q.push_back(c);
        end else if (op == 6'h00 && fn == 6'h08) begin
            c.pc = 1'b1; c.br = 2'd3;
            exp_q.push_back(c);
        end else if (op == 6'h0d || op == 6'h0f) begin
            exp_q.push_back(c);
            c.st = 3'd2; c.ext = 1'b0; c.b = 1'b1;
            c.alu = (op == 6'h0f) ? 3'd3 : 3'd2;
            exp_q.push_back(c);
            c.st = 3'd4; c.wa = 2'd0; c.wd = 2'd0; c.br = 2'd0;
            c.rw = 1'b1; c.pc = 1'b1;
            exp_q.push_back(c);
        end else if (op == 6'h23 || op == 6'h2b) begin
            exp_q.push_back(c);
            c.st = 3'd2; c.ext = 1'b1; c.b = 1'b1; c.alu = 3'd0;
            exp_q.push_back(c);
            c.st = 3'd3;
            if (op == 6'h2b) begin
                c.mw = 1'b1; c.pc = 1'b1; c.br = 2'd0;
                exp_q.push_back(c);
            end else begin
                exp_q.push_back(c);
                c.st = 3'd4; c.wa = 2'd0; c.wd = 2'd1; c.br = 2'd0;
                c.rw = 1'b1; c.pc = 1'b1;
                exp_q.push_back(c);
            end
        end else if (op == 6'h04) begin
            exp_q.push_back(c);
            c.st = 3'd2; c.b = 1'b0; c.alu = 3'd1; c.pc = 1'b1; c.br = 2'd1;
            exp_q.push_back(c);
        end else if (op == 6'h02) begin
            c.pc = 1'b1; c.br = 2'd2;
            exp_q.push_back(c);
        end else if (op == 6'h03) begin
            c.pc = 1'b1; c.br = 2'd2; c.rw = 1'b1; c.wa = 2'd2; c.wd = 2'd2;
            exp_q.push_back(c);
        end else begin
            c.pc = 1'b1; c.br = 2'd0;
            exp_q.push_back(c);
        end
    endtask

    // Entered just after a posedge with the DUT in FETCH; returns the same way.
    task automatic run_model(input logic [5:0] op, input logic [5:0] fn);
        obs_t o;
        build(op, fn);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 0) begin
                mif.op = 6'($urandom);
                mif.func = 6'($urandom);
            end
            @(negedge clk);
            o = get_obs();
            chk($sformatf("op%h/fn%h cyc%0d", op, fn, k),
                {14'd0, o}, {14'd0, exp_q[k]});
            if (k == 0) begin
                mif.op = op;
                mif.func = fn;
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("op%h/fn%h back-to-fetch", op, fn),
            {29'd0, mif.state}, 32'd0);
    endtask

    task automatic run_len(input vec_t v);
        int n;
        int pcs;
        logic [1:0] br;
        logic rw;
        logic mw;
        n = 0; pcs = 0; br = '0; rw = 1'b0; mw = 1'b0;
        mif.op = v.op;
        mif.func = v.func;
        do begin
            @(negedge clk);
            n++;
            if (mif.pcwrite) begin
                pcs++;
                br = mif.brctr;
                rw = mif.regwrite;
                mw = mif.memwrite;
            end
            @(posedge clk);
            #1;
        end while (mif.state != 3'd0 && n < 10);
        chk($sformatf("tbl op%h len", v.op), 32'(n), 32'(v.ncyc));
        chk($sformatf("tbl op%h pcw", v.op), 32'(pcs), 32'd1);
        chk($sformatf("tbl op%h ctl", v.op), {28'd0, br, rw, mw},
            {28'd0, v.br, v.rw, v.mw});
    endtask

    vec_t tbl[12];
    obs_t o;

    initial begin
        tbl[0]  = '{6'h00, 6'h21, 4, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{6'h00, 6'h23, 4, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{6'h00, 6'h08, 2, 2'd3, 1'b0, 1'b0};
        tbl[3]  = '{6'h00, 6'h00, 2, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{6'h0d, 6'h15, 4, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{6'h0f, 6'h00, 4, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{6'h23, 6'h00, 5, 2'd0, 1'b1, 1'b0};
        tbl[7]  = '{6'h2b, 6'h00, 4, 2'd0, 1'b0, 1'b1};
        tbl[8]  = '{6'h04, 6'h00, 3, 2'd1, 1'b0, 1'b0};
        tbl[9]  = '{6'h02, 6'h00, 2, 2'd2, 1'b0, 1'b0};
        tbl[10] = '{6'h03, 6'h00, 2, 2'd2, 1'b1, 1'b0};
        tbl[11] = '{6'h3f, 6'h21, 2, 2'd0, 1'b0, 1'b0};

        mif.op = '0; mif.func = '0;
        mif2.op = '0; mif2.func = '0;
        repeat (2) @(posedge clk);
        #1;
        o = get_obs();
        chk("reset outputs", {14'd0, o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
`ifdef MC_PERF_CNT_EN
        chk("cyc_cnt after reset", mif.cyc_cnt, 32'd0);
        chk("ret_cnt after reset", mif.ret_cnt, 32'd0);
`endif

        for (int i = 0; i < 12; i++)
            run_len(tbl[i]);

        run_model(6'h00, 6'h21);
        run_model(6'h23, 6'h00);
        run_model(6'h2b, 6'h00);
        run_model(6'h04, 6'h00);
        run_model(6'h03, 6'h00);
        for (int i = 0; i < 40; i++) begin
            logic [5:0] rop;
            logic [5:0] rfn;
            logic [5:0] pool [12];
            pool = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23,
                     6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f, 6'h00};
            rop = pool[$urandom_range(0, 11)];
            case ($urandom_range(0, 3))
                0: rfn = 6'h21;
                1: rfn = 6'h23;
                2: rfn = 6'h08;
                default: rfn = 6'($urandom);
            endcase
            if ($urandom_range(0, 4) == 0)
                rop = 6'($urandom);
            run_model(rop, rfn);
        end

        // Reset dropped in the MEM state of a lw.
        mif.op = 6'h23;
        mif.func = 6'h00;
        repeat (4) @(negedge clk);
        chk("lw reaches MEM", {29'd0, mif.state}, 32'd3);
        rst = 1'b0;
        #1;
        o = get_obs();
        chk("async reset mid-lw", {14'd0, o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
`ifdef MC_PERF_CNT_EN
        chk("cyc_cnt after mid reset", mif.cyc_cnt, 32'd0);
        chk("ret_cnt after mid reset", mif.ret_cnt, 32'd0);
`endif
        run_model(6'h00, 6'h21);
`ifdef MC_PERF_CNT_EN
        chk("ret_cnt after addu", mif.ret_cnt, 32'd1);
        chk("cyc_cnt after addu", mif.cyc_cnt, 32'd4);
`endif

        // Slow instruction memory: three FETCH cycles, then unknown op.
        @(posedge clk);
        #1;
        rst2 = 1'b1;
        mif2.op = 6'h3f;
        mif2.func = 6'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("wait2 fetch%0d", k),
                {28'd0, mif2.state, mif2.irwrite},
                {28'd0, 3'd0, (k == 2)});
        end
        @(negedge clk);
        chk("wait2 unknown decode",
            {26'd0, mif2.state, mif2.pcwrite, mif2.brctr},
            {26'd0, 3'd1, 1'b1, 2'd0});
        chk("wait2 unknown no write",
            {30'd0, mif2.regwrite, mif2.memwrite}, 32'd0);
        @(posedge clk);
        #1;
        chk("wait2 back to fetch", {29'd0, mif2.state}, 32'd0);
        @(negedge clk);
        chk("wait2 refetch holds", {31'd0, mif2.irwrite}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit that sits on the far side of the datapath's op/func ↔ control-signal interface.
- Consumes `op`/`func` decoded from the instruction register and sequences FETCH/DECODE/EXE/MEM/WB.
- Drives every datapath control input, plus `pcwrite` and `irwrite` strobes, so the PC, IR, GRF and DM each update only in the correct cycle.
- Replaces the single-cycle combinational controller for the multi-cycle CPU.

Parameters:
- IMEM_WAIT, 0, extra FETCH cycles inserted before `irwrite` for slow instruction memory (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- op  input  6  instruction [31:26] from decoder.
- func  input  6  instruction [5:0] from decoder.
- irwrite  output  1  load IR on this edge.
- pcwrite  output  1  update PC on this edge; next PC selected by brctr.
- brctr  output  2  00 pc+4, 01 beq (taken iff datapath equal=1), 10 j/jal target, 11 jr (rs).
- wactr  output  2  00 rt, 01 rd, 10 $31.
- wdctr  output  2  00 ALU, 01 DM, 10 pc+4.
- extctr  output  1  0 zero-extend, 1 sign-extend.
- bctr  output  1  0 GRF rd2, 1 extender.
- aluctr  output  3  000 add, 001 sub, 010 or, 011 lui (B<<16).
- regwrite  output  1  GRF write enable.
- memwrite  output  1  DM write enable.
- state  output  3  current state: 0 FETCH, 1 DECODE, 2 EXE, 3 MEM, 4 WB.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, wait counter=0.
  - irwrite, pcwrite, regwrite, memwrite forced 0 while rst=0.
  - Selectors (brctr, wactr, wdctr, extctr, bctr, aluctr) = 0.
- After rst deasserts, the first clock edge is the first FETCH edge.
- Outputs are combinational from state, op, func and the wait counter (Moore per state). No output depends on `equal`.
- FETCH:
  - Counter counts 0..IMEM_WAIT.
  - irwrite=1 only when counter==IMEM_WAIT; then go to DECODE and clear the counter.
  - With IMEM_WAIT=0, FETCH lasts 1 cycle.
- Instruction set and per-state controls. Selectors not listed hold the values of the previous state of the same instruction, so datapath combinational paths stay stable into write edges.
  - addu (op 000000, func 100001) / subu (func 100011):
    - DECODE→EXE.
    - EXE: bctr=0, aluctr=000 (addu) or 001 (subu).
    - →WB: wactr=01, wdctr=00, regwrite=1, pcwrite=1, brctr=00.
    - 4 cycles total.
  - jr (op 0, func 001000): DECODE asserts pcwrite=1, brctr=11, then →FETCH. 2 cycles.
  - Other R-type func: treated as nop; pcwrite=1, brctr=00 in DECODE, then →FETCH. 2 cycles.
  - ori (001101): EXE extctr=0, bctr=1, aluctr=010; WB writes rt from ALU, pcwrite=1, brctr=00. 4 cycles.
  - lui (001111): as ori but aluctr=011. 4 cycles.
  - lw (100011):
    - EXE extctr=1, bctr=1, aluctr=000.
    - MEM: no enables.
    - WB: wactr=00, wdctr=01, regwrite=1, pcwrite=1, brctr=00.
    - 5 cycles.
  - sw (101011): EXE as lw; MEM memwrite=1, pcwrite=1, brctr=00, then →FETCH. 4 cycles.
  - beq (000100): EXE bctr=0, aluctr=001, pcwrite=1, brctr=01, then →FETCH. 3 cycles.
  - j (000010): DECODE pcwrite=1, brctr=10, then →FETCH. 2 cycles.
  - jal (000011):
    - DECODE asserts, on one edge: regwrite=1, wactr=10, wdctr=10, pcwrite=1, brctr=10.
    - The old pc+4 is written to $31 on the same edge the PC changes.
    - 2 cycles.
  - Unknown op: nop path, as for other R-type func. Never hangs.
- pcwrite is asserted for exactly one cycle per instruction, always in its final state.
- memwrite and regwrite are never both 1 except for jal's regwrite with pcwrite.
- op/func are sampled only in DECODE and later (IR stable after irwrite). Changes during FETCH are ignored.
- Reset mid-instruction: immediate return to FETCH with all enables 0. No partial GRF/DM write occurs after rst falls.
- Illegal state encodings (5..7) go to FETCH on the next edge with all enables 0.

Optional Feature:
- Macro: `MC_PERF_CNT_EN`.
- When defined, adds two outputs, both reset to 0 by rst and wrapping modulo 2^32:
  - cyc_cnt [31:0]: increments every clock.
  - ret_cnt [31:0]: increments on every edge with pcwrite=1.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- addu $3,$1,$2 (op 0, func 100001), IMEM_WAIT=0: states 0,1,2,4. irwrite only in cycle 1; regwrite+pcwrite, wactr=01, wdctr=00 only in cycle 4.
- lw (op 100011): 5 cycles. extctr=1, bctr=1 in EXE; wdctr=01, regwrite=1 in WB; memwrite never 1.
- sw then beq: sw memwrite=1 with pcwrite=1 in MEM (cycle 4). beq ends in EXE (cycle 3) with aluctr=001, brctr=01, pcwrite=1.
- jal: DECODE shows regwrite=1, wactr=10, wdctr=10, brctr=10, pcwrite=1; next state FETCH.
- IMEM_WAIT=2: FETCH holds 3 cycles, irwrite only in the third. Unknown op 111111 returns to FETCH after DECODE with pcwrite=1, brctr=00.
- Drop rst during lw MEM: state=0 and all enables 0 immediately (before the next edge). After release, a new FETCH proceeds. With `MC_PERF_CNT_EN`, both counters read 0 after release.
